// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle shift/rotate unit.
// Applies one log2 stage per clock, starting from amount[0], behind
// valid/ready request and response ports.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | applying one power-of-two stage per clock
// DONE  | result presented, held until the consumer takes it
module iterative_shifter #(
  parameter  int BitWidth = 32,
  localparam int L        = $clog2(BitWidth)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BitWidth-1:0] in_data,
  input  logic [L-1:0]        amount,
  input  logic                arith1_logic0,
  input  logic                left1_right0,
  input  logic                shift1_rotate0,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BitWidth-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [L-1:0] LastStep = L[L-1:0] - 1'b1;

  state_e              state_q;
  state_e              state_d;

  logic [BitWidth-1:0] acc_q;
  logic [L-1:0]        amount_q;
  logic [L-1:0]        step_q;
  logic                arith_q;
  logic                left_q;
  logic                shift_q;
  logic                sign_q;

  logic [BitWidth-1:0] stage_res;
  logic                stage_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SHIFT always lasts exactly L cycles, whatever the amount
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (step_q == LastStep) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; result is forced to zero unless it is being presented
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc_q;
      end
      default: ;
    endcase
  end

  // One stage of the shifter: distance 2**step, with the amount bit that enables it
  always_comb begin
    stage_res = acc_q;
    stage_en  = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (step_q == k[L-1:0]) begin
        stage_en = amount_q[k];
        if (!shift_q) begin
          if (left_q) begin
            stage_res = (acc_q << (2**k)) | (acc_q >> (BitWidth - 2**k));
          end else begin
            stage_res = (acc_q >> (2**k)) | (acc_q << (BitWidth - 2**k));
          end
        end else if (left_q) begin
          stage_res = acc_q << (2**k);
        end else if (arith_q) begin
          stage_res = (acc_q >> (2**k)) | ({BitWidth{sign_q}} << (BitWidth - 2**k));
        end else begin
          stage_res = acc_q >> (2**k);
        end
      end
    end
  end

  // Operand capture on accept, then one conditional stage per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      amount_q <= '0;
      step_q   <= '0;
      arith_q  <= 1'b0;
      left_q   <= 1'b0;
      shift_q  <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q    <= in_data;
            amount_q <= amount;
            arith_q  <= arith1_logic0;
            left_q   <= left1_right0;
            shift_q  <= shift1_rotate0;
            sign_q   <= in_data[BitWidth-1];
            step_q   <= '0;
          end
        end
        SHIFT: begin
          if (stage_en) begin
            acc_q <= stage_res;
          end
          step_q <= step_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed-vector bench for iterative_shifter (BitWidth = 32).
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  amount;
  logic        arith1_logic0;
  logic        left1_right0;
  logic        shift1_rotate0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  iterative_shifter #(.BitWidth(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .amount         (amount),
    .arith1_logic0  (arith1_logic0),
    .left1_right0   (left1_right0),
    .shift1_rotate0 (shift1_rotate0),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  amt;
    logic        arith;
    logic        left;
    logic        shift;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, scramble inputs during SHIFT, measure latency,
  // optionally stall the output, then transfer and check the return to IDLE.
  task automatic do_op(input vec_t v);
    int lat;
    check({v.name, "/in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    in_valid       = 1'b1;
    in_data        = v.data;
    amount         = v.amt;
    arith1_logic0  = v.arith;
    left1_right0   = v.left;
    shift1_rotate0 = v.shift;
    step();
    in_data        = ~v.data;
    amount         = ~v.amt;
    arith1_logic0  = ~v.arith;
    left1_right0   = ~v.left;
    shift1_rotate0 = ~v.shift;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({v.name, "/latency"}, lat, 32'd5);
    check({v.name, "/data"}, out_data, v.exp);
    check({v.name, "/in_ready_done"}, {31'b0, in_ready}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      step();
      check({v.name, "/hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({v.name, "/hold_data"}, out_data, v.exp);
      check({v.name, "/hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({v.name, "/valid_after_xfer"}, {31'b0, out_valid}, 32'd0);
    check({v.name, "/ready_after_xfer"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t rv;
    //          name        data           amt    ar    l     sh    exp            hold
    vecs[0]  = '{"sll31",   32'h0000_0001, 5'd31, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 0};
    vecs[1]  = '{"sra4",    32'h8000_0000, 5'd4,  1'b1, 1'b0, 1'b1, 32'hF800_0000, 0};
    vecs[2]  = '{"srl4",    32'h8000_0000, 5'd4,  1'b0, 1'b0, 1'b1, 32'h0800_0000, 0};
    vecs[3]  = '{"ror4",    32'h0000_00F1, 5'd4,  1'b0, 1'b0, 1'b0, 32'h1000_000F, 0};
    vecs[4]  = '{"rol1",    32'h8000_0001, 5'd1,  1'b0, 1'b1, 1'b0, 32'h0000_0003, 0};
    vecs[5]  = '{"ror4_ar", 32'h0000_00F1, 5'd4,  1'b1, 1'b0, 1'b0, 32'h1000_000F, 0};
    vecs[6]  = '{"rol1_ar", 32'h8000_0001, 5'd1,  1'b1, 1'b1, 1'b0, 32'h0000_0003, 0};
    vecs[7]  = '{"amt0",    32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 3};
    vecs[8]  = '{"sra31",   32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{"sra31_p", 32'h7000_0000, 5'd31, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 0};
    vecs[10] = '{"sll4_ar", 32'hFFFF_FFFF, 5'd4,  1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 0};
    vecs[11] = '{"srl12",   32'h1234_5678, 5'd12, 1'b0, 1'b0, 1'b1, 32'h0001_2345, 0};
    vecs[12] = '{"rol8",    32'h1234_5678, 5'd8,  1'b0, 1'b1, 1'b0, 32'h3456_7812, 0};
    vecs[13] = '{"ror31",   32'h1234_5678, 5'd31, 1'b0, 1'b0, 1'b0, 32'h2468_ACF0, 0};
    vecs[14] = '{"sra21",   32'h8000_00F0, 5'd21, 1'b1, 1'b0, 1'b1, 32'hFFFF_FC00, 0};

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    amount         = '0;
    arith1_logic0  = 1'b0;
    left1_right0   = 1'b0;
    shift1_rotate0 = 1'b0;
    out_ready      = 1'b0;
    #22;
    check("reset/in_ready", {31'b0, in_ready}, 32'd1);
    check("reset/out_valid", {31'b0, out_valid}, 32'd0);
    check("reset/out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i]);
    end

    // Reset in the middle of SHIFT
    in_valid       = 1'b1;
    in_data        = 32'hFFFF_FFFF;
    amount         = 5'd3;
    arith1_logic0  = 1'b0;
    left1_right0   = 1'b1;
    shift1_rotate0 = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("midrst/in_ready_before", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst/out_data", out_data, 32'h0);
    check("midrst/in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rv = '{"post_rst_sll2", 32'h0000_0003, 5'd2, 1'b0, 1'b1, 1'b1, 32'h0000_000C, 0};
    do_op(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
